// File: rtl/mpu_fetch_pkg.sv
// Shared fetch widths: memory word, instruction pointer, word address and window size.
package mpu_fetch_pkg;
   localparam int unsigned WordW    = 64;
   localparam int unsigned IpW      = 16;
   localparam int unsigned AdrW     = 13;
   localparam int unsigned MaxIsize = 6;
   localparam int unsigned WinW     = 8 * MaxIsize;
   localparam int unsigned BufW     = 2 * WordW;
endpackage

// File: rtl/mpu_fetch_align.sv
// Combinational byte aligner: picks the 6-byte window starting at byte offset off of a 16-byte buffer.
module mpu_fetch_align
   import mpu_fetch_pkg::*;
(
   input  logic [BufW-1:0] buf_w,
   input  logic [2:0]      off,
   output logic [WinW-1:0] win
);

   logic [6:0] base;

   always_comb begin
      win  = '0;
      base = '0;
      for (int k = 0; k < int'(MaxIsize); k++) begin
         base             = {1'b0, off, 3'b000} + 7'(8 * k);
         win[8*k +: 8]    = buf_w[base +: 8];
      end
   end

endmodule

// File: rtl/mpu_fetch.sv
// Instruction fetch unit: two-word buffer feeding a 48-bit window at ip.
// Define MPU_FETCH_SHIFT_EN to move to the next sequential word with a 1-cycle shift/refetch.
module mpu_fetch
   import mpu_fetch_pkg::*;
(
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             start,
   input  logic [IpW-1:0]   start_addr,
   output logic [AdrW-1:0]  m_adr,
   output logic             m_re,
   input  logic [WordW-1:0] m_dat_r,
   output logic [WinW-1:0]  i,
   output logic             i_valid,
   output logic [IpW-1:0]   ip,
   input  logic             i_ack,
   input  logic [IpW-1:0]   isize,
   input  logic             jmp,
   input  logic [IpW-1:0]   jaddr,
   input  logic             err,
   output logic             halted
);

   typedef enum logic [2:0] {
      StIdle,
      StFill0,
      StFill1,
      StCapt,
      StReady,
      StHalt
   } state_e;

   state_e            state_q, state_d;
   logic [IpW-1:0]    ip_q, ip_d;
   logic [WordW-1:0]  buf0_q, buf0_d;
   logic [WordW-1:0]  buf1_q, buf1_d;
   logic [IpW-1:0]    nip;
   logic [AdrW-1:0]   word, word_nxt;

   always_comb begin
      state_d  = state_q;
      ip_d     = ip_q;
      buf0_d   = buf0_q;
      buf1_d   = buf1_q;
      m_re     = 1'b0;
      m_adr    = '0;
      word     = ip_q[15:3];
      nip      = jmp ? jaddr : ip_q + isize;
      word_nxt = nip[15:3];

      case (state_q)
         StIdle: ;
         StFill0: begin
            m_re    = 1'b1;
            m_adr   = word;
            state_d = StFill1;
         end
         StFill1: begin
            m_re    = 1'b1;
            m_adr   = word + 13'd1;
            buf0_d  = m_dat_r;
            state_d = StCapt;
         end
         StCapt: begin
            buf1_d  = m_dat_r;
            state_d = StReady;
         end
         StReady: begin
            if (i_ack) begin
               if (err || (!jmp && isize == '0)) begin
                  state_d = StHalt;
               end else begin
                  ip_d = nip;
                  if (word_nxt == word) begin
                     state_d = StReady;
`ifdef MPU_FETCH_SHIFT_EN
                  // Read of W+2 is issued on the ack cycle so CAPT sees its data.
                  end else if (!jmp && word_nxt == word + 13'd1) begin
                     buf0_d  = buf1_q;
                     m_re    = 1'b1;
                     m_adr   = word + 13'd2;
                     state_d = StCapt;
`endif
                  end else begin
                     state_d = StFill0;
                  end
               end
            end
         end
         StHalt: ;
         default: state_d = StIdle;
      endcase

      // A restart abandons any word still in flight.
      if (start) begin
         state_d = StFill0;
         ip_d    = start_addr;
         buf0_d  = buf0_q;
         buf1_d  = buf1_q;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= StIdle;
         ip_q    <= '0;
         buf0_q  <= '0;
         buf1_q  <= '0;
      end else begin
         state_q <= state_d;
         ip_q    <= ip_d;
         buf0_q  <= buf0_d;
         buf1_q  <= buf1_d;
      end
   end

   mpu_fetch_align u_align (
      .buf_w ({buf1_q, buf0_q}),
      .off   (ip_q[2:0]),
      .win   (i)
   );

   assign ip      = ip_q;
   assign i_valid = (state_q == StReady);
   assign halted  = (state_q == StHalt);

endmodule

// File: tb/tb_mpu_fetch.sv
// Randomized self-checking bench for mpu_fetch against a byte-address reference model.
module tb_mpu_fetch;

`ifdef MPU_FETCH_SHIFT_EN
   localparam int SeqBub = 1;
`else
   localparam int SeqBub = 3;
`endif

   logic        sys_clk    = 1'b0;
   logic        sys_rst_n  = 1'b0;
   logic        start      = 1'b0;
   logic [15:0] start_addr = '0;
   logic [12:0] m_adr;
   logic        m_re;
   logic [63:0] m_dat_r    = '0;
   logic [47:0] i;
   logic        i_valid;
   logic [15:0] ip;
   logic        i_ack      = 1'b0;
   logic [15:0] isize      = '0;
   logic        jmp        = 1'b0;
   logic [15:0] jaddr      = '0;
   logic        err        = 1'b0;
   logic        halted;

   int          n_checks = 0;
   int          n_fails  = 0;
   logic [15:0] m_ip     = '0;

   always #5 sys_clk = ~sys_clk;

   mpu_fetch dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .start      (start),
      .start_addr (start_addr),
      .m_adr      (m_adr),
      .m_re       (m_re),
      .m_dat_r    (m_dat_r),
      .i          (i),
      .i_valid    (i_valid),
      .ip         (ip),
      .i_ack      (i_ack),
      .isize      (isize),
      .jmp        (jmp),
      .jaddr      (jaddr),
      .err        (err),
      .halted     (halted)
   );

   // Memory: byte at address a holds a[7:0]; data appears the cycle after m_re.
   function automatic logic [63:0] mem_word(input logic [12:0] a);
      logic [63:0] w;
      logic [15:0] base;
      base = {a, 3'b000};
      for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(base + 16'(k));
      return w;
   endfunction

   always @(posedge sys_clk) if (m_re) m_dat_r <= mem_word(m_adr);

   function automatic logic [47:0] exp_win(input logic [15:0] a);
      logic [47:0] w;
      for (int k = 0; k < 6; k++) w[8*k +: 8] = 8'(a + 16'(k));
      return w;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h (ip model %04h)", tag, got, exp, m_ip);
      end
   endtask

   task automatic wait_ready(input int base, input int exp_bub);
      int n = base;
      while (i_valid !== 1'b1 && n < 12) begin
         n++;
         @(negedge sys_clk);
      end
      check("bubble", 64'(n), 64'(exp_bub));
      check("ip", 64'(ip), 64'(m_ip));
      check("window", 64'(i), 64'(exp_win(m_ip)));
   endtask

   task automatic do_start(input logic [15:0] addr);
      m_ip       = addr;
      start      = 1'b1;
      start_addr = addr;
      @(negedge sys_clk);
      start = 1'b0;
      check("fill0_re", 64'(m_re), 64'd1);
      check("fill0_adr", 64'(m_adr), 64'(addr[15:3]));
      @(negedge sys_clk);
      check("fill1_adr", 64'(m_adr), 64'(13'(addr[15:3] + 13'd1)));
      check("halted_clr", 64'(halted), 64'd0);
      @(negedge sys_clk);
      wait_ready(2, 3);
   endtask

   task automatic do_ack(input logic [15:0] sz, input logic j, input logic [15:0] ja,
                         input logic e, output logic was_halt);
      logic [15:0] nip;
      int          bub;
      nip      = j ? ja : m_ip + sz;
      was_halt = e || (!j && sz == 16'd0);
      i_ack = 1'b1;
      isize = sz;
      jmp   = j;
      jaddr = ja;
      err   = e;
      @(negedge sys_clk);
      i_ack = 1'b0;
      jmp   = 1'b0;
      err   = 1'b0;
      if (was_halt) begin
         check("halt_flag", 64'(halted), 64'd1);
         check("halt_valid", 64'(i_valid), 64'd0);
         check("halt_ip", 64'(ip), 64'(m_ip));
      end else begin
         if (nip[15:3] == m_ip[15:3]) bub = 0;
         else if (!j && nip[15:3] == 13'(m_ip[15:3] + 13'd1)) bub = SeqBub;
         else bub = 3;
         m_ip = nip;
         wait_ready(0, bub);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"}, 64'(i_valid), 64'd0);
      check({tag, "_ip"}, 64'(ip), 64'd0);
      check({tag, "_halted"}, 64'(halted), 64'd0);
      check({tag, "_re"}, 64'(m_re), 64'd0);
      check({tag, "_adr"}, 64'(m_adr), 64'd0);
      check({tag, "_win"}, 64'(i), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic h;
      int   r;
      #2;
      check_reset_state("rst");
      @(negedge sys_clk);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);

      do_start(16'h0000);
      do_ack(16'd5, 1'b0, 16'h0000, 1'b0, h);
      do_ack(16'd4, 1'b0, 16'h0000, 1'b0, h);
      do_ack(16'd5, 1'b1, 16'h0100, 1'b0, h);
      do_start(16'hFFFA);
      do_ack(16'd6, 1'b0, 16'h0000, 1'b0, h);
      do_start(16'hFFFC);
      do_ack(16'd1, 1'b0, 16'h0000, 1'b1, h);

      // Acks while halted must be ignored.
      i_ack = 1'b1;
      isize = 16'd4;
      @(negedge sys_clk);
      i_ack = 1'b0;
      @(negedge sys_clk);
      check("halt_ignore_flag", 64'(halted), 64'd1);
      check("halt_ignore_ip", 64'(ip), 64'(m_ip));
      check("halt_ignore_valid", 64'(i_valid), 64'd0);
      do_start(16'h0010);

      // Restart during FILL1.
      start      = 1'b1;
      start_addr = 16'h0020;
      @(negedge sys_clk);
      start = 1'b0;
      @(negedge sys_clk);
      start      = 1'b1;
      start_addr = 16'h0040;
      m_ip       = 16'h0040;
      @(negedge sys_clk);
      start = 1'b0;
      wait_ready(0, 3);

      // Reset during CAPT: nothing in flight may land in the buffers.
      start      = 1'b1;
      start_addr = 16'h0083;
      @(negedge sys_clk);
      start = 1'b0;
      @(negedge sys_clk);
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      #1;
      check_reset_state("midrst");
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      @(negedge sys_clk);
      check_reset_state("postrst");
      m_ip = 16'h0000;

      do_start(16'($urandom));
      for (int n = 0; n < 200; n++) begin
         r = $urandom_range(0, 99);
         if (r < 5) begin
            do_start(16'($urandom));
         end else if (r < 8) begin
            do_ack(16'($urandom_range(1, 6)), 1'b0, 16'h0000, 1'b1, h);
         end else if (r < 14) begin
            do_ack(16'($urandom_range(0, 6)), 1'b1, 16'($urandom), 1'b0, h);
         end else if (r < 20) begin
            do_ack(16'($urandom_range(0, 6)), 1'b1, m_ip + 16'($urandom_range(0, 12)), 1'b0, h);
         end else if (r < 95) begin
            do_ack(16'($urandom_range(1, 6)), 1'b0, 16'h0000, 1'b0, h);
         end else begin
            do_ack(16'($urandom_range(0, 40)), 1'b0, 16'h0000, 1'b0, h);
         end
         if (h) do_start(16'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
